// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the 16-bit memory bus initiator.
package mem_bus_pkg;

   localparam int MEM_DATA_W = 16;
   localparam int ADDR_W_DEF = 16;
   localparam int LEN_W_DEF  = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_RD_ADDR,
      ST_RD_CAP,
      ST_RESP
   } state_t;

endpackage

// File: rtl/mem_bus_tristate.sv
// Bidirectional data-bus pad: drives the bus when enabled, otherwise Z; returns the bus value.
import mem_bus_pkg::*;

module mem_bus_tristate (
   input  logic                  drive_en,
   input  logic [MEM_DATA_W-1:0] wr_data,
   output logic [MEM_DATA_W-1:0] rd_data,
   inout  wire  [MEM_DATA_W-1:0] bus
);

   assign bus     = drive_en ? wr_data : {MEM_DATA_W{1'bz}};
   assign rd_data = bus;

endmodule

// File: rtl/mem_bus_master.sv
// Word read/write initiator for the single-port 16-bit memory.
// Optional read bursts are enabled with `define MEM_BUS_MASTER_BURST_EN.
import mem_bus_pkg::*;

module mem_bus_master #(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [MEM_DATA_W-1:0] req_wdata,
   input  logic [LEN_W-1:0]      req_len,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [MEM_DATA_W-1:0] rsp_data,
   output logic                  rsp_last,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic                  mem_rw,
   output logic                  mem_en,
   output logic                  mem_oe,
   inout  wire  [MEM_DATA_W-1:0] mem_data
);

   state_t                state_q, state_d;
   logic [ADDR_W-1:0]     addr_q;
   logic [MEM_DATA_W-1:0] wdata_q;
   logic [MEM_DATA_W-1:0] rsp_data_q;
   logic [MEM_DATA_W-1:0] bus_rd;
   logic                  more_words;
   logic                  accept;

   assign accept = (state_q == ST_IDLE) && req_valid;

`ifdef MEM_BUS_MASTER_BURST_EN
   // Remaining words after the one currently held in the response register.
   logic [LEN_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (accept) begin
         cnt_q <= req_write ? '0 : req_len;
      end else if (state_q == ST_RESP && rsp_ready && more_words) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign more_words = (cnt_q != '0);
`else
   logic unused_req_len;
   assign unused_req_len = ^req_len;
   assign more_words     = 1'b0;
`endif

   // Control state and latched request fields
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         rsp_data_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q <= req_addr;
         end else if (state_q == ST_RESP && rsp_ready && more_words) begin
            addr_q <= addr_q + ADDR_W'(1);
         end
         if (state_q == ST_RD_CAP) begin
            rsp_data_q <= bus_rd;
         end
      end
   end

   // Write data is only ever driven in WRITE, so it needs no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         wdata_q <= req_wdata;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d = req_write ? ST_WRITE : ST_RD_ADDR;
            end
         end
         ST_WRITE:   state_d = ST_IDLE;
         ST_RD_ADDR: state_d = ST_RD_CAP;
         ST_RD_CAP:  state_d = ST_RESP;
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = more_words ? ST_RD_ADDR : ST_IDLE;
            end
         end
         default:    state_d = ST_IDLE;
      endcase
   end

   // Memory controls decode purely from registered state.
   assign req_ready = (state_q == ST_IDLE);
   assign mem_en    = (state_q == ST_WRITE) || (state_q == ST_RD_ADDR) || (state_q == ST_RD_CAP);
   assign mem_rw    = (state_q != ST_WRITE);
   assign mem_oe    = (state_q == ST_RD_ADDR) || (state_q == ST_RD_CAP);
   assign mem_addr  = addr_q;

   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_data  = rsp_data_q;
   assign rsp_last  = (state_q == ST_RESP) && !more_words;

   mem_bus_tristate u_tristate (
      .drive_en (state_q == ST_WRITE),
      .wr_data  (wdata_q),
      .rd_data  (bus_rd),
      .bus      (mem_data)
   );

endmodule
